// File: rtl/conv_mac_sequencer_pkg.sv
// Shared definitions for the convolution MAC sequencer: state encoding and
// the default operand-buffer geometry.
package conv_mac_sequencer_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int BUFFER_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Command, buffer-read and result-handshake signals of the MAC sequencer.
// master = sequencer side, slave = command source / buffer / result consumer.
interface conv_mac_sequencer_if
    import conv_mac_sequencer_pkg::*;
#(
    parameter int DataWidth   = DATA_WIDTH,
    parameter int BufferWidth = BUFFER_WIDTH,
    parameter int AccWidth    = 2*DataWidth + BufferWidth
);
    logic                   start;
    logic [BufferWidth-1:0] BaseA;
    logic [BufferWidth-1:0] BaseB;
    logic [BufferWidth:0]   Len;
    logic [BufferWidth-1:0] R_Addr1;
    logic [BufferWidth-1:0] R_Addr2;
    logic [DataWidth-1:0]   DataIn1;
    logic [DataWidth-1:0]   DataIn2;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [AccWidth-1:0]    Result;

    modport master (
        input  start, BaseA, BaseB, Len, DataIn1, DataIn2, out_ready,
        output R_Addr1, R_Addr2, busy, out_valid, Result
    );

    modport slave (
        output start, BaseA, BaseB, Len, DataIn1, DataIn2, out_ready,
        input  R_Addr1, R_Addr2, busy, out_valid, Result
    );

endinterface

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate: combinational full-precision product,
// sign-extended and added into a registered accumulator with clear/enable.
module conv_mac_unit #(
    parameter int DataWidth = 8,
    parameter int AccWidth  = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic signed [DataWidth-1:0] i_a,
    input  logic signed [DataWidth-1:0] i_b,
    output logic signed [AccWidth-1:0]  o_acc
);

    logic signed [2*DataWidth-1:0] w_prod;
    logic signed [AccWidth-1:0]    w_prod_ext;
    logic signed [AccWidth-1:0]    r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(AccWidth-2*DataWidth){w_prod[2*DataWidth-1]}}, w_prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_mac_sequencer.sv
// Walks two read addresses of the operand buffer over a Len-tap window,
// accumulates the signed products and offers the sum on a valid/ready port.
module conv_mac_sequencer
    import conv_mac_sequencer_pkg::*;
#(
    parameter int DataWidth   = DATA_WIDTH,
    parameter int BufferWidth = BUFFER_WIDTH,
    parameter int BufferSize  = 2**BufferWidth,
    parameter int AccWidth    = 2*DataWidth + BufferWidth
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 clk_en,
    conv_mac_sequencer_if.master bus
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BufferWidth:0]   r_taps_left;
    logic [BufferWidth-1:0] r_addr1;
    logic [BufferWidth-1:0] r_addr2;
    logic [AccWidth-1:0]    r_result;
    logic                   r_out_valid;
    logic                   w_accept;
    logic                   w_clear;
    logic                   w_acc_en;
    logic signed [AccWidth-1:0] w_acc;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_clear  = clk_en && w_accept;
    assign w_acc_en = clk_en && (r_state == ST_ACC);

    conv_mac_unit #(
        .DataWidth(DataWidth),
        .AccWidth (AccWidth)
    ) u_mac (
        .clk    (clk),
        .rst    (aclr),
        .i_clear(w_clear),
        .i_en   (w_acc_en),
        .i_a    (bus.DataIn1),
        .i_b    (bus.DataIn2),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.Len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (r_taps_left == (BufferWidth+1)'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // DONE spends its first cycle capturing the sum, so out_valid and Result
    // come from registers and Result survives the clear of the next start.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_taps_left <= '0;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_addr1     <= bus.BaseA;
                        r_addr2     <= bus.BaseB;
                        r_taps_left <= bus.Len;
                    end
                end
                ST_ACC: begin
                    r_addr1     <= BufferWidth'((int'(r_addr1) + 1) % BufferSize);
                    r_addr2     <= BufferWidth'((int'(r_addr2) + 1) % BufferSize);
                    r_taps_left <= r_taps_left - (BufferWidth+1)'(1);
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_result    <= w_acc;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.R_Addr1   = r_addr1;
    assign bus.R_Addr2   = r_addr2;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.Result    = r_result;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer: the driver pushes model results,
// a negedge monitor pops and compares when out_valid rises.
module tb_conv_mac_sequencer;

    localparam int DW = 8;
    localparam int BW = 2;
    localparam int AW = 2*DW + BW;

    typedef struct {
        longint res;
        int     lat;
        int     t0;
    } exp_t;

    logic clk;
    logic aclr;
    logic clk_en;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   n_transfers;
    int   n_ops;
    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur;
    bit   prev_valid;
    longint last_res;
    logic signed [DW-1:0] mem [4];

    conv_mac_sequencer_if #(.DataWidth(DW), .BufferWidth(BW), .AccWidth(AW)) bus ();

    conv_mac_sequencer #(.DataWidth(DW), .BufferWidth(BW), .BufferSize(4), .AccWidth(AW)) dut (
        .clk   (clk),
        .aclr  (aclr),
        .clk_en(clk_en),
        .bus   (bus)
    );

    assign bus.DataIn1 = mem[bus.R_Addr1];
    assign bus.DataIn2 = mem[bus.R_Addr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic longint ref_mac(input int ba, input int bb, input int len);
        longint s = 0;
        for (int k = 0; k < len; k++) begin
            s += longint'(mem[(ba + k) % 4]) * longint'(mem[(bb + k) % 4]);
        end
        return s;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (aclr) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("result", longint'($signed(bus.Result)), cur.res);
                    chk("latency", cyc - cur.t0, cur.lat);
                end
            end else if (bus.out_valid && have_cur) begin
                chk("result_hold", longint'($signed(bus.Result)), cur.res);
            end
            if (prev_valid && !bus.out_valid) begin
                chk("result_keep", longint'($signed(bus.Result)), last_res);
            end
            if (bus.out_valid && bus.out_ready && clk_en) n_transfers++;
            last_res   = longint'($signed(bus.Result));
            prev_valid = bus.out_valid;
        end
    end

    // Issue a start; optionally freeze clk_en for 3 cycles after freeze_at
    // enabled edges; optionally wait for completion with random backpressure.
    task automatic run_op(input int ba, input int bb, input int len,
                          input int freeze_at, input bit rand_ready, input bit wait_done);
        exp_t e;
        logic [BW-1:0] a1, a2;
        bus.BaseA = BW'(ba);
        bus.BaseB = BW'(bb);
        bus.Len   = (BW+1)'(len);
        bus.start = 1'b1;
        e.res = ref_mac(ba, bb, len);
        e.lat = len + 1 + ((freeze_at >= 0) ? 3 : 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.t0 = cyc;
        exp_q.push_back(e);
        n_ops++;
        if (freeze_at >= 0) begin
            repeat (freeze_at) begin
                @(posedge clk);
                #1;
            end
            a1 = bus.R_Addr1;
            a2 = bus.R_Addr2;
            clk_en = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("freeze_addr1", bus.R_Addr1, a1);
                chk("freeze_addr2", bus.R_Addr2, a2);
            end
            clk_en = 1'b1;
        end
        if (wait_done) begin
            for (int k = 0; k < 200 && bus.busy; k++) begin
                if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'b1;
            chk("op_done_busy", bus.busy, 0);
            chk("op_done_valid", bus.out_valid, 0);
        end
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; n_transfers = 0; n_ops = 0;
        have_cur = 1'b0; prev_valid = 1'b0; last_res = 0;
        aclr = 1'b1; clk_en = 1'b1;
        bus.start = 1'b0; bus.BaseA = '0; bus.BaseB = '0; bus.Len = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr1", bus.R_Addr1, 0);
        chk("rst_addr2", bus.R_Addr2, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_result", bus.Result, 0);
        aclr = 1'b0;
        @(posedge clk);
        #1;

        mem[0] = 8'sd1; mem[1] = 8'sd2; mem[2] = 8'sd3; mem[3] = 8'sd4;
        run_op(0, 0, 4, -1, 0, 1);

        mem[0] = -8'sd2; mem[1] = 8'sd3; mem[2] = 8'sd5; mem[3] = -8'sd1;
        run_op(2, 3, 3, -1, 0, 1);

        run_op(0, 0, 0, -1, 0, 1);

        mem[1] = -8'sd128;
        run_op(1, 1, 1, -1, 0, 1);

        // Backpressure with ignored starts, then start coinciding with the transfer
        mem[0] = 8'sd7; mem[1] = -8'sd3; mem[2] = 8'sd11; mem[3] = -8'sd9;
        bus.out_ready = 1'b0;
        run_op(3, 0, 4, -1, 0, 0);
        for (int k = 0; k < 20 && !bus.out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid_seen", bus.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 1 || k == 3);
            bus.BaseA = 2'd1; bus.BaseB = 2'd2; bus.Len = 3'd2;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("bp_busy", bus.busy, 1);
            chk("bp_valid_held", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("bp_xfer_valid", bus.out_valid, 0);
        chk("bp_xfer_busy", bus.busy, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_still_idle", bus.busy, 0);

        // clk_en freeze mid-ACC
        mem[0] = -8'sd50; mem[1] = 8'sd100; mem[2] = -8'sd128; mem[3] = 8'sd127;
        run_op(1, 2, 4, 2, 0, 1);

        // Abort with aclr mid-ACC: nothing is pushed, so any out_valid is flagged
        bus.BaseA = 2'd0; bus.BaseB = 2'd1; bus.Len = 3'd4; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("abort_busy_before", bus.busy, 1);
        aclr = 1'b1;
        #1;
        chk("abort_addr1", bus.R_Addr1, 0);
        chk("abort_addr2", bus.R_Addr2, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_result", bus.Result, 0);
        repeat (2) @(posedge clk);
        #1;
        aclr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_valid", bus.out_valid, 0);

        // Randomized operations with random backpressure
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 4; k++) mem[k] = DW'($urandom);
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)), -1, 1, 1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("transfer_count", n_transfers, n_ops);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
